planta_termica: RTL and testbench

//  Closed-loop thermal plant and sensor emulator: the producer end of the temperature link.

---
 rtl/planta_termica_pkg.sv | 27 ++
 rtl/planta_termica_generador_tick.sv | 31 +++
 rtl/planta_termica.sv | 115 +++++++++++
 tb/tb_planta_termica.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/planta_termica_pkg.sv
// Shared types and limits for the thermal plant emulator.
// The plant mode doubles as the state of the top-level FSM.
package pkg_planta;

    localparam int TEMP_W = 11;
    localparam int T_MIN  = -1024;
    localparam int T_MAX  = 1023;

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        CALENTANDO = 2'd1,
        ENFRIANDO  = 2'd2,
        CONFLICTO  = 2'd3
    } modo_planta_t;

    function automatic modo_planta_t decodificar_modo(input logic cal, input logic ven);
        modo_planta_t m;
        case ({cal, ven})
            2'b10:   m = CALENTANDO;
            2'b01:   m = ENFRIANDO;
            2'b11:   m = CONFLICTO;
            default: m = REPOSO;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/planta_termica_generador_tick.sv
// Plant update prescaler: counts 0..DIV_TICK-1 while enabled and flags the last count.
// A synchronous clear restarts the interval (used when a temperature is forced).
module generador_tick #(
    parameter int DIV_TICK = 10
) (
    input  logic clk,
    input  logic arst_n,
    input  logic i_habilitar,
    input  logic i_limpiar,
    output logic o_tick
);
    localparam int CW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
    localparam logic [CW-1:0] C_ULTIMO = CW'(DIV_TICK - 1);

    logic [CW-1:0] r_cnt;
    logic          w_ultimo;

    assign w_ultimo = (r_cnt == C_ULTIMO);
    assign o_tick   = i_habilitar && w_ultimo;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt <= '0;
        end else if (i_limpiar) begin
            r_cnt <= '0;
        end else if (i_habilitar) begin
            r_cnt <= w_ultimo ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/planta_termica.sv
// Closed-loop thermal plant / sensor emulator: integrates heater and fan commands into a
// saturating signed temperature, updated once per prescaler tick, with forced-load fault injection.
module planta_termica
    import pkg_planta::*;
#(
    parameter int DIV_TICK   = 10,
    parameter int T_INICIAL  = 250,
    parameter int T_AMBIENTE = 220,
    parameter int PASO_CAL   = 3,
    parameter int PASO_VEN   = 2,
    parameter int PASO_AMB   = 1
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     calefactor,
    input  logic                     ventilador,
    input  logic                     habilitar,
    input  logic                     forzar_valid,
    input  logic signed [TEMP_W-1:0] forzar_temp,
    output logic signed [TEMP_W-1:0] temp_salida,
    output logic                     temp_valida,
    output logic                     saturado,
    output logic [1:0]               modo
);
    // One extra bit of headroom so the raw sum never wraps before clamping.
    localparam int SW = TEMP_W + 1;
    localparam logic signed [SW-1:0] C_T_AMB    = SW'(T_AMBIENTE);
    localparam logic signed [SW-1:0] C_PASO_CAL = SW'(PASO_CAL);
    localparam logic signed [SW-1:0] C_PASO_VEN = SW'(PASO_VEN);
    localparam logic signed [SW-1:0] C_PASO_AMB = SW'(PASO_AMB);
    localparam logic signed [SW-1:0] C_T_MIN    = SW'(T_MIN);
    localparam logic signed [SW-1:0] C_T_MAX    = SW'(T_MAX);

    logic                     w_tick;
    modo_planta_t             w_modo_sig;
    logic signed [SW-1:0]     w_temp_ext;
    logic signed [SW-1:0]     w_suma;
    logic signed [SW-1:0]     w_limitada;
    logic                     w_sat;

    modo_planta_t             r_modo;
    logic signed [TEMP_W-1:0] r_temp;
    logic                     r_valida;
    logic                     r_saturado;

    generador_tick #(
        .DIV_TICK (DIV_TICK)
    ) u_generador_tick (
        .clk         (clk),
        .arst_n      (arst_n),
        .i_habilitar (habilitar),
        .i_limpiar   (forzar_valid),
        .o_tick      (w_tick)
    );

    assign w_modo_sig = decodificar_modo(calefactor, ventilador);
    assign w_temp_ext = {r_temp[TEMP_W-1], r_temp};

    always_comb begin
        w_suma = w_temp_ext;
        case (w_modo_sig)
            REPOSO: begin
                // Approach ambient without ever stepping past it.
                if (w_temp_ext < C_T_AMB) begin
                    w_suma = ((C_T_AMB - w_temp_ext) > C_PASO_AMB) ? w_temp_ext + C_PASO_AMB : C_T_AMB;
                end else if (w_temp_ext > C_T_AMB) begin
                    w_suma = ((w_temp_ext - C_T_AMB) > C_PASO_AMB) ? w_temp_ext - C_PASO_AMB : C_T_AMB;
                end
            end
            CALENTANDO: w_suma = w_temp_ext + C_PASO_CAL;
            ENFRIANDO:  w_suma = w_temp_ext - C_PASO_VEN;
            default:    w_suma = w_temp_ext;
        endcase
    end

    always_comb begin
        w_limitada = w_suma;
        w_sat      = 1'b0;
        if (w_suma > C_T_MAX) begin
            w_limitada = C_T_MAX;
            w_sat      = 1'b1;
        end else if (w_suma < C_T_MIN) begin
            w_limitada = C_T_MIN;
            w_sat      = 1'b1;
        end
    end

    // Mode FSM and plant outputs; a force always wins over a coincident tick.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_modo     <= REPOSO;
            r_temp     <= TEMP_W'(T_INICIAL);
            r_valida   <= 1'b0;
            r_saturado <= 1'b0;
        end else begin
            r_valida <= 1'b0;
            if (forzar_valid) begin
                r_temp     <= forzar_temp;
                r_valida   <= 1'b1;
                r_saturado <= 1'b0;
            end else if (w_tick) begin
                r_modo     <= w_modo_sig;
                r_temp     <= w_limitada[TEMP_W-1:0];
                r_valida   <= 1'b1;
                r_saturado <= w_sat;
            end
        end
    end

    assign temp_salida = r_temp;
    assign temp_valida = r_valida;
    assign saturado    = r_saturado;
    assign modo        = r_modo;

endmodule

// File: tb/tb_planta_termica.sv
// Self-checking bench for planta_termica: per-cycle reference model, vector table of
// force-then-tick cases, and hand-written sequences for reset, enable and force races.
module tb_planta_termica;

    localparam int DIV = 10;

    logic               clk = 1'b0;
    logic               arst_n = 1'b0;
    logic               calefactor = 1'b0;
    logic               ventilador = 1'b0;
    logic               habilitar = 1'b1;
    logic               forzar_valid = 1'b0;
    logic signed [10:0] forzar_temp = '0;
    logic signed [10:0] temp_salida;
    logic               temp_valida;
    logic               saturado;
    logic [1:0]         modo;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_temp = 250;
    int m_val  = 0;
    int m_sat  = 0;
    int m_modo = 0;
    int m_cnt  = 0;

    planta_termica dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .calefactor   (calefactor),
        .ventilador   (ventilador),
        .habilitar    (habilitar),
        .forzar_valid (forzar_valid),
        .forzar_temp  (forzar_temp),
        .temp_salida  (temp_salida),
        .temp_valida  (temp_valida),
        .saturado     (saturado),
        .modo         (modo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_temp = 250; m_val = 0; m_sat = 0; m_modo = 0; m_cnt = 0;
    endtask

    // Plant rule from plain integer arithmetic, clamped to the 11-bit signed range.
    task automatic model_update(input bit cal, input bit ven);
        int t;
        t = m_temp;
        if (cal && !ven) begin
            t = t + 3; m_modo = 1;
        end else if (!cal && ven) begin
            t = t - 2; m_modo = 2;
        end else if (cal && ven) begin
            m_modo = 3;
        end else begin
            m_modo = 0;
            if (t < 220) t = t + ((220 - t) < 1 ? (220 - t) : 1);
            else if (t > 220) t = t - ((t - 220) < 1 ? (t - 220) : 1);
        end
        m_sat = 0;
        if (t > 1023) begin t = 1023; m_sat = 1; end
        if (t < -1024) begin t = -1024; m_sat = 1; end
        m_temp = t;
    endtask

    task automatic compare_model();
        chk("temp_salida", int'(temp_salida), m_temp);
        chk("temp_valida", int'(temp_valida), m_val);
        chk("saturado", int'(saturado), m_sat);
        chk("modo", int'(modo), m_modo);
    endtask

    // One clock: model follows the inputs sampled at the edge, outputs checked on the falling edge.
    task automatic clk_cycle();
        @(posedge clk);
        if (forzar_valid) begin
            m_temp = int'(forzar_temp); m_val = 1; m_sat = 0; m_cnt = 0;
        end else if (habilitar && m_cnt == DIV - 1) begin
            model_update(calefactor, ventilador);
            m_val = 1; m_cnt = 0;
        end else begin
            m_val = 0;
            if (habilitar) m_cnt++;
        end
        @(negedge clk);
        compare_model();
    endtask

    task automatic wait_pulse(input int limit, output int ncyc);
        ncyc = 0;
        for (int i = 0; i < limit; i++) begin
            clk_cycle();
            ncyc++;
            if (temp_valida) return;
        end
        chk("pulse_timeout", 0, 1);
    endtask

    task automatic forzar(input int v);
        forzar_valid = 1'b1;
        forzar_temp  = 11'(v);
        clk_cycle();
        forzar_valid = 1'b0;
    endtask

    typedef struct {
        int f;
        bit cal;
        bit ven;
        int exp_t;
        bit exp_s;
        int exp_m;
    } vec_t;

    vec_t tabla[10];

    initial begin
        int n;
        int held;
        int cal_seq[5];

        tabla[0] = '{1022, 1'b1, 1'b0, 1023, 1'b1, 1};
        tabla[1] = '{-1023, 1'b0, 1'b1, -1024, 1'b1, 2};
        tabla[2] = '{221, 1'b0, 1'b0, 220, 1'b0, 0};
        tabla[3] = '{220, 1'b0, 1'b0, 220, 1'b0, 0};
        tabla[4] = '{219, 1'b0, 1'b0, 220, 1'b0, 0};
        tabla[5] = '{500, 1'b1, 1'b1, 500, 1'b0, 3};
        tabla[6] = '{1023, 1'b0, 1'b1, 1021, 1'b0, 2};
        tabla[7] = '{-1024, 1'b1, 1'b0, -1021, 1'b0, 1};
        tabla[8] = '{1021, 1'b1, 1'b0, 1023, 1'b1, 1};
        tabla[9] = '{0, 1'b0, 1'b1, -2, 1'b0, 2};
        cal_seq = '{253, 256, 259, 262, 265};

        // reset state and first pulse latency after release
        model_reset();
        #12;
        chk("reset_temp", int'(temp_salida), 250);
        chk("reset_valida", int'(temp_valida), 0);
        chk("reset_modo", int'(modo), 0);
        @(negedge clk);
        arst_n = 1'b1;
        wait_pulse(15, n);
        chk("first_pulse_latency", n, DIV);

        // heating from 250 after a fresh reset
        @(posedge clk); #3;
        arst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_temp", int'(temp_salida), 250);
        chk("rst_mid_valida", int'(temp_valida), 0);
        chk("rst_mid_modo", int'(modo), 0);
        @(negedge clk);
        arst_n = 1'b1;
        calefactor = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_pulse(15, n);
            chk("heat_interval", n, DIV);
            chk("heat_value", int'(temp_salida), cal_seq[k]);
            chk("heat_modo", int'(modo), 1);
        end
        calefactor = 1'b0;

        // force-then-tick vector table
        foreach (tabla[i]) begin
            forzar(tabla[i].f);
            chk("force_sat_clear", int'(saturado), 0);
            calefactor = tabla[i].cal;
            ventilador = tabla[i].ven;
            wait_pulse(15, n);
            chk("vec_interval", n, DIV);
            chk("vec_temp", int'(temp_salida), tabla[i].exp_t);
            chk("vec_sat", int'(saturado), int'(tabla[i].exp_s));
            chk("vec_modo", int'(modo), tabla[i].exp_m);
        end

        // idle at ambient stays at ambient
        forzar(221);
        calefactor = 1'b0; ventilador = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_pulse(15, n);
            chk("idle_hold", int'(temp_salida), 220);
        end

        // force lands on the tick cycle: forced value wins, counter restarts
        calefactor = 1'b1;
        for (int k = 0; k < 2 * DIV && m_cnt != DIV - 1; k++) clk_cycle();
        forzar(77);
        chk("race_value", int'(temp_salida), 77);
        chk("race_modo_kept", int'(modo), 0);
        wait_pulse(15, n);
        chk("race_restart", n, DIV);
        chk("race_next", int'(temp_salida), 80);
        calefactor = 1'b0;

        // enable gating, then resume from the held count
        for (int k = 0; k < 4; k++) clk_cycle();
        held = m_cnt;
        habilitar = 1'b0;
        n = 0;
        for (int k = 0; k < 25; k++) begin
            clk_cycle();
            if (temp_valida) n++;
        end
        chk("disabled_pulses", n, 0);
        habilitar = 1'b1;
        wait_pulse(15, n);
        chk("resume_interval", n, DIV - held);

        // force honoured while disabled
        habilitar = 1'b0;
        forzar(-300);
        chk("force_disabled", int'(temp_salida), -300);
        habilitar = 1'b1;

        // reset mid-count discards the partial interval
        for (int k = 0; k < 6; k++) clk_cycle();
        @(posedge clk); #3;
        arst_n = 1'b0;
        model_reset();
        #1;
        chk("rst2_temp", int'(temp_salida), 250);
        @(negedge clk);
        arst_n = 1'b1;
        wait_pulse(15, n);
        chk("rst2_latency", n, DIV);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            calefactor   = 1'($urandom_range(0, 1));
            ventilador   = 1'($urandom_range(0, 1));
            habilitar    = ($urandom_range(0, 9) != 0);
            forzar_valid = ($urandom_range(0, 39) == 0);
            forzar_temp  = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 3) == 0) forzar_temp = 11'($urandom_range(1015, 1023));
            clk_cycle();
        end
        forzar_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout actual=%0t required=<5000000", $time);
        $fatal(1, "timeout");
    end

endmodule
